// File: rtl/pa_ifu_ipack_ctrl_pkg.sv
// Shared constants for the instruction package buffer.
package pa_ifu_ipack_ctrl_pkg;
  localparam int unsigned IPACK_HALF_W = 16;
  localparam logic [1:0]  INST32_OPC   = 2'b11;
endpackage

// File: rtl/pa_ifu_ipack_ctrl_if.sv
// Fetch-side and ID-side handshake bundle of the ipack buffer.
interface pa_ifu_ipack_ctrl_if;
  logic        ipack_buf_flush;
  logic        ifetch_ipack_vld;
  logic [31:0] ifetch_ipack_data;
  logic        ifetch_ipack_hi_only;
  logic        ifetch_ipack_acc_err;
  logic        ipack_ifetch_full;
  logic        id_ipack_ready;
  logic        ipack_id_vld;
  logic [31:0] ipack_id_inst;
  logic        ipack_id_is_16;
  logic        ipack_id_acc_err;

  modport master (
    output ipack_buf_flush, ifetch_ipack_vld, ifetch_ipack_data, ifetch_ipack_hi_only,
           ifetch_ipack_acc_err, id_ipack_ready,
    input  ipack_ifetch_full, ipack_id_vld, ipack_id_inst, ipack_id_is_16, ipack_id_acc_err
  );

  modport slave (
    input  ipack_buf_flush, ifetch_ipack_vld, ifetch_ipack_data, ifetch_ipack_hi_only,
           ifetch_ipack_acc_err, id_ipack_ready,
    output ipack_ifetch_full, ipack_id_vld, ipack_id_inst, ipack_id_is_16, ipack_id_acc_err
  );
endinterface

// File: rtl/pa_ifu_ipack_entry.sv
// One halfword entry: valid bit on the buffer clock, payload on the create-gated clock.
module pa_ifu_ipack_entry
  import pa_ifu_ipack_ctrl_pkg::*;
(
  input  logic                    ipack_cpuclk,
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  input  logic                    cp0_yy_clk_en,
  input  logic                    cp0_ifu_icg_en,
  input  logic                    pad_yy_icg_scan_en,
  input  logic                    i_flush,
  input  logic                    i_create_en,
  input  logic                    i_create_icg_en,
  input  logic                    i_retire_en,
  input  logic [IPACK_HALF_W-1:0] i_upd_inst,
  input  logic                    i_upd_acc_err,
  output logic                    o_vld,
  output logic [IPACK_HALF_W-1:0] o_inst,
  output logic                    o_acc_err
);
  logic                    r_vld;
  logic [IPACK_HALF_W-1:0] r_inst;
  logic                    r_acc_err;
  logic                    w_clk_on;

  // Clock-gate enable term; payload only moves when the gate is open and a create hits.
  assign w_clk_on = (cp0_yy_clk_en & (i_create_icg_en | ~cp0_ifu_icg_en)) | pad_yy_icg_scan_en;

  // Create wins over retire so a wrapped same-cycle recreate stays valid.
  always_ff @(posedge ipack_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)        r_vld <= 1'b0;
    else if (i_flush)     r_vld <= 1'b0;
    else if (i_create_en) r_vld <= 1'b1;
    else if (i_retire_en) r_vld <= 1'b0;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_inst    <= '0;
      r_acc_err <= 1'b0;
    end else if (w_clk_on && i_create_en) begin
      r_inst    <= i_upd_inst;
      r_acc_err <= i_upd_acc_err;
    end
  end

  assign o_vld     = r_vld;
  assign o_inst    = r_inst;
  assign o_acc_err = r_acc_err;
endmodule

// File: rtl/pa_ifu_ipack_ctrl.sv
// Instruction package buffer controller: halfword circular buffer between fetch and ID.
module pa_ifu_ipack_ctrl
  import pa_ifu_ipack_ctrl_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 4,
  parameter int unsigned PTR_W     = 2
) (
  input  logic                ipack_cpuclk,
  input  logic                cpurst_b,
  input  logic                forever_cpuclk,
  input  logic                cp0_yy_clk_en,
  input  logic                cp0_ifu_icg_en,
  input  logic                pad_yy_icg_scan_en,
  pa_ifu_ipack_ctrl_if.slave  ipack_if
);
  localparam int unsigned CntW = PTR_W + 1;

  logic [PTR_W-1:0]        r_cptr, r_rptr;
  logic [CntW-1:0]         r_count;
  logic [PTR_W-1:0]        w_cptr_p1, w_rptr_p1;
  logic                    w_create, w_fire, w_is_16, w_vld;
  logic [CntW-1:0]         w_create_num, w_retire_num;
  logic                    w_ent_vld [ENTRY_NUM];
  logic                    w_ent_err [ENTRY_NUM];
  logic [IPACK_HALF_W-1:0] w_ent_inst [ENTRY_NUM];
  logic [IPACK_HALF_W-1:0] w_head, w_next;
  logic                    w_head_vld, w_next_vld, w_head_err, w_next_err;

  assign w_cptr_p1 = r_cptr + PTR_W'(1);
  assign w_rptr_p1 = r_rptr + PTR_W'(1);
  assign ipack_if.ipack_ifetch_full = (r_count > CntW'(ENTRY_NUM - 2));
  assign w_create = ipack_if.ifetch_ipack_vld & ~ipack_if.ipack_ifetch_full &
                    ~ipack_if.ipack_buf_flush;
  assign w_fire   = w_vld & ipack_if.id_ipack_ready;
  assign w_create_num = !w_create ? '0 : (ipack_if.ifetch_ipack_hi_only ? CntW'(1) : CntW'(2));
  assign w_retire_num = !w_fire ? '0 : (w_is_16 ? CntW'(1) : CntW'(2));

  for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_entry
    localparam logic [PTR_W-1:0] Idx = PTR_W'(i);
    logic w_lo_hit, w_hi_hit, w_retire;

    assign w_lo_hit = w_create & ~ipack_if.ifetch_ipack_hi_only & (r_cptr == Idx);
    assign w_hi_hit = w_create & (ipack_if.ifetch_ipack_hi_only ? (r_cptr == Idx)
                                                                : (w_cptr_p1 == Idx));
    assign w_retire = w_fire & ((r_rptr == Idx) | (~w_is_16 & (w_rptr_p1 == Idx)));

    pa_ifu_ipack_entry u_entry (
      .ipack_cpuclk       (ipack_cpuclk),
      .forever_cpuclk     (forever_cpuclk),
      .cpurst_b           (cpurst_b),
      .cp0_yy_clk_en      (cp0_yy_clk_en),
      .cp0_ifu_icg_en     (cp0_ifu_icg_en),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .i_flush            (ipack_if.ipack_buf_flush),
      .i_create_en        (w_lo_hit | w_hi_hit),
      .i_create_icg_en    (w_lo_hit | w_hi_hit),
      .i_retire_en        (w_retire),
      .i_upd_inst         (w_hi_hit ? ipack_if.ifetch_ipack_data[31:16]
                                    : ipack_if.ifetch_ipack_data[15:0]),
      .i_upd_acc_err      (ipack_if.ifetch_ipack_acc_err),
      .o_vld              (w_ent_vld[i]),
      .o_inst             (w_ent_inst[i]),
      .o_acc_err          (w_ent_err[i])
    );
  end

  assign w_head     = w_ent_inst[r_rptr];
  assign w_next     = w_ent_inst[w_rptr_p1];
  assign w_head_vld = w_ent_vld[r_rptr];
  assign w_next_vld = w_ent_vld[w_rptr_p1];
  assign w_head_err = w_ent_err[r_rptr];
  assign w_next_err = w_ent_err[w_rptr_p1];

  // Outputs forced to zero while nothing is presented, so reset values read as 0.
  always_comb begin
    w_vld                     = 1'b0;
    w_is_16                   = 1'b1;
    ipack_if.ipack_id_inst    = '0;
    ipack_if.ipack_id_is_16   = 1'b0;
    ipack_if.ipack_id_acc_err = 1'b0;
    if (w_head_vld && w_head_err) begin
      w_vld                     = 1'b1;
      ipack_if.ipack_id_inst    = {16'b0, w_head};
      ipack_if.ipack_id_is_16   = 1'b1;
      ipack_if.ipack_id_acc_err = 1'b1;
    end else if (w_head[1:0] != INST32_OPC) begin
      w_vld = w_head_vld;
      if (w_head_vld) begin
        ipack_if.ipack_id_inst  = {16'b0, w_head};
        ipack_if.ipack_id_is_16 = 1'b1;
      end
    end else begin
      w_is_16 = 1'b0;
      w_vld   = w_head_vld & w_next_vld;
      if (w_vld) begin
        ipack_if.ipack_id_inst    = {w_next, w_head};
        ipack_if.ipack_id_acc_err = w_next_err;
      end
    end
  end
  assign ipack_if.ipack_id_vld = w_vld;

  always_ff @(posedge ipack_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_cptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (ipack_if.ipack_buf_flush) begin
      r_cptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_cptr  <= r_cptr + PTR_W'(w_create_num);
      r_rptr  <= r_rptr + PTR_W'(w_retire_num);
      r_count <= r_count + w_create_num - w_retire_num;
    end
  end
endmodule
